// File: rtl/stq_data_bank.sv
// rtl/stq_data_bank.sv - store-queue data array with byte-valid tracking and registered check ports
//
// Parameters:
//   WIDTH  entry data width in bits (multiple of 8)
//   DEPTH  number of entries
//   NWR    write port count
//   NCHK   check port count (>= 3); ports NCHK-2 and NCHK-1 are the fallback sources
// Ports:
//   clk       clock, all state on rising edge
//   rst       asynchronous active-high reset
//   wr_en     per-port one-hot entry select, port w at [w*DEPTH +: DEPTH]
//   wr_data   per-port write data, port w at [w*WIDTH +: WIDTH]
//   wr_be     per-port byte enables, port w at [w*WIDTH/8 +: WIDTH/8]
//   free_en   per-entry retire flag, clears the byte-valid mask
//   chk_en    per-port entry select, port p at [p*DEPTH +: DEPTH]
//   chk_fb    per-port {fb1,fb0} fallback select, used when the select is zero
//   chk_data  registered read data per check port
//   chk_bv    registered byte-valid mask per check port
//   chk_err   registered flag: more than one select bit was set
module stq_data_bank #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int NWR   = 2,
    parameter int NCHK  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NWR*DEPTH-1:0]      wr_en,
    input  logic [NWR*WIDTH-1:0]      wr_data,
    input  logic [NWR*WIDTH/8-1:0]    wr_be,
    input  logic [DEPTH-1:0]          free_en,
    input  logic [NCHK*DEPTH-1:0]     chk_en,
    input  logic [2*NCHK-1:0]         chk_fb,
    output logic [NCHK*WIDTH-1:0]     chk_data,
    output logic [NCHK*WIDTH/8-1:0]   chk_bv,
    output logic [NCHK-1:0]           chk_err
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [NB-1:0]    bv_q   [DEPTH];

    // Raw per-port lookup result (before fallback substitution)
    logic [WIDTH-1:0] src_data [NCHK];
    logic [NB-1:0]    src_bv   [NCHK];
    logic [NCHK-1:0]  src_any;
    logic [NCHK-1:0]  src_err;

    // Final per-port value after fallback, fed to the output register
    logic [WIDTH-1:0] fin_data [NCHK];
    logic [NB-1:0]    fin_bv   [NCHK];

    // Array update. The free clear is applied first so that a same-cycle
    // write re-sets exactly its own bytes. Ports are visited in ascending
    // order, so the highest-numbered port enabling a byte wins it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                data_q[e] <= '0;
                bv_q[e]   <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (free_en[e]) begin
                    bv_q[e] <= '0;
                end
                for (int w = 0; w < NWR; w++) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wr_en[w*DEPTH + e] && wr_be[w*NB + b]) begin
                            data_q[e][b*8 +: 8] <= wr_data[w*WIDTH + b*8 +: 8];
                            bv_q[e][b]          <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Lookup: OR-reduce over all selected entries. A second hit on the
    // same port flags the select as malformed.
    always_comb begin
        src_any = '0;
        src_err = '0;
        for (int p = 0; p < NCHK; p++) begin
            src_data[p] = '0;
            src_bv[p]   = '0;
            for (int e = 0; e < DEPTH; e++) begin
                if (chk_en[p*DEPTH + e]) begin
                    if (src_any[p]) begin
                        src_err[p] = 1'b1;
                    end
                    src_any[p]  = 1'b1;
                    src_data[p] = src_data[p] | data_q[e];
                    src_bv[p]   = src_bv[p] | bv_q[e];
                end
            end
        end
    end

    // Fallback uses the raw lookup of the two tail ports, never their own
    // fallback result, so there is no chained lookup. fb1 has priority.
    always_comb begin
        for (int p = 0; p < NCHK; p++) begin
            fin_data[p] = src_data[p];
            fin_bv[p]   = src_bv[p];
            if (!src_any[p] && (p < NCHK - 2)) begin
                if (chk_fb[2*p + 1]) begin
                    fin_data[p] = src_data[NCHK-1];
                    fin_bv[p]   = src_bv[NCHK-1];
                end else if (chk_fb[2*p]) begin
                    fin_data[p] = src_data[NCHK-2];
                    fin_bv[p]   = src_bv[NCHK-2];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_data <= '0;
            chk_bv   <= '0;
            chk_err  <= '0;
        end else begin
            for (int p = 0; p < NCHK; p++) begin
                chk_data[p*WIDTH +: WIDTH] <= fin_data[p];
                chk_bv[p*NB +: NB]         <= fin_bv[p];
            end
            chk_err <= src_err;
        end
    end

endmodule
